// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell, LSB first, fixed N-cycle RUN.
// Produces the difference, the unsigned borrow, the zero flag and signed overflow.
module serial_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         zero,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  // Handshake: start is accepted only in IDLE or DONE, where A/B are captured;
  // busy is high for exactly N cycles afterwards, then done pulses for one cycle
  // with diff/borrow/zero/ovf valid. Those results hold until the next done.
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sr, b_sr, d_sr;
  logic          bin;
  logic          a_msb, b_msb;
  logic          accept, last_bit;
  logic          a0, b0, d_bit, bout;
  logic [N-1:0]  d_next;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;
  assign last_bit  = (cnt == CW'(N - 1));

  always_comb begin
    a0     = a_sr[0];
    b0     = b_sr[0];
    d_bit  = a0 ^ b0 ^ bin;
    bout   = (~a0 & b0) | (~(a0 ^ b0) & bin);
    d_next = {d_bit, d_sr[N-1:1]};
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      bin    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr  <= A;
        b_sr  <= B;
        d_sr  <= '0;
        cnt   <= '0;
        bin   <= 1'b0;
        a_msb <= A[N-1];
        b_msb <= B[N-1];
      end else if (state == RUN) begin
        // Operands shift right so bit 0 always feeds the cell; result bits enter at the top.
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        d_sr <= d_next;
        bin  <= bout;
        cnt  <= cnt + CW'(1);
        if (last_bit) begin
          diff   <= d_next;
          borrow <= bout;
          zero   <= (d_next == '0);
          ovf    <= (a_msb != b_msb) && (d_next[N-1] != a_msb);
        end
      end
    end
  end

endmodule
